// File: rtl/hotel_checkout.sv
// Seven-slot hotel guest table with a sequential checkout engine: it scans the
// slots for the guest, bills the stay, and frees the slot.
module hotel_checkout (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        book_valid,
  input  logic [3:0]  book_id,
  input  logic [2:0]  book_room,
  input  logic        book_ac,
  input  logic        book_wifi,
  input  logic [4:0]  book_day,
  input  logic        co_req,
  input  logic [3:0]  co_id,
  input  logic [4:0]  co_day,
  output logic        busy,
  output logic        co_done,
  output logic        co_miss,
  output logic [2:0]  co_room,
  output logic [15:0] co_bill,
  output logic [6:0]  occ
);
  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_CALC, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [6:0]       r_occ, r_occ_q, r_ac, r_wifi;
  logic [6:0][3:0]  r_id;
  logic [6:0][4:0]  r_day;
  logic [3:0]       r_cid;
  logic [4:0]       r_cday;
  logic [2:0]       r_idx, r_room;
  logic [15:0]      r_bill;
  logic             r_miss;

  logic             w_match, w_scan_miss, w_book;
  logic [4:0]       w_stay, w_nights;
  logic [9:0]       w_rate;
  logic [15:0]      w_bill;

  assign w_match     = r_occ[r_idx] && (r_id[r_idx] == r_cid);
  assign w_scan_miss = (r_cid == 4'd0) || (!w_match && r_idx == 3'd6);
  assign w_book      = (r_state == S_IDLE) && book_valid &&
                       (book_id != 4'd0) && (book_room != 3'd7);

  // Day counter wraps at 32; a same-day checkout still pays one night.
  assign w_stay   = r_cday - r_day[r_idx];
  assign w_nights = (w_stay == 5'd0) ? 5'd1 : w_stay;

  always_comb begin
    w_rate = 10'd500;
    if (r_idx <= 3'd1)      w_rate = 10'd700;
    else if (r_idx <= 3'd5) w_rate = 10'd400;
    if (r_ac[r_idx])   w_rate = w_rate + 10'd200;
    if (r_wifi[r_idx]) w_rate = w_rate + 10'd100;
  end

  assign w_bill = {6'd0, w_rate} * {11'd0, w_nights};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (co_req) w_next = S_SEARCH;
      S_SEARCH: begin
        if (w_scan_miss)  w_next = S_DONE;
        else if (w_match) w_next = S_CALC;
      end
      S_CALC:   w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ   <= '0;
      r_occ_q <= '0;
      r_ac    <= '0;
      r_wifi  <= '0;
      r_id    <= '0;
      r_day   <= '0;
      r_cid   <= '0;
      r_cday  <= '0;
      r_idx   <= '0;
      r_room  <= '0;
      r_bill  <= '0;
      r_miss  <= 1'b0;
    end else begin
      r_occ_q <= r_occ;
      // Writes only happen in IDLE, so they never collide with the CALC clear.
      if (w_book) begin
        r_occ[book_room]  <= 1'b1;
        r_id[book_room]   <= book_id;
        r_ac[book_room]   <= book_ac;
        r_wifi[book_room] <= book_wifi;
        r_day[book_room]  <= book_day;
      end
      case (r_state)
        S_IDLE: if (co_req) begin
          r_cid  <= co_id;
          r_cday <= co_day;
          r_idx  <= 3'd0;
        end
        S_SEARCH: begin
          if (w_scan_miss) begin
            r_miss <= 1'b1;
            r_bill <= 16'd0;
            r_room <= 3'd0;
          end else if (!w_match) begin
            r_idx <= r_idx + 3'd1;
          end
        end
        S_CALC: begin
          r_bill       <= w_bill;
          r_room       <= r_idx;
          r_miss       <= 1'b0;
          r_occ[r_idx] <= 1'b0;
          r_id[r_idx]  <= 4'd0;
        end
        default: ;
      endcase
    end
  end

  assign busy    = (r_state != S_IDLE);
  assign co_done = (r_state == S_DONE);
  assign co_miss = r_miss;
  assign co_room = r_room;
  assign co_bill = r_bill;
  assign occ     = r_occ_q;
endmodule

// File: tb/tb_hotel_checkout.sv
// Self-checking bench for hotel_checkout: directed scenarios plus randomized
// booking/checkout traffic against a slot-table reference model.
module tb_hotel_checkout;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        book_valid = 1'b0;
  logic [3:0]  book_id = '0;
  logic [2:0]  book_room = '0;
  logic        book_ac = 1'b0, book_wifi = 1'b0;
  logic [4:0]  book_day = '0;
  logic        co_req = 1'b0;
  logic [3:0]  co_id = '0;
  logic [4:0]  co_day = '0;
  logic        busy, co_done, co_miss;
  logic [2:0]  co_room;
  logic [15:0] co_bill;
  logic [6:0]  occ;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference table
  bit      m_occ[7];
  int      m_id[7], m_day[7];
  bit      m_ac[7], m_wifi[7];

  hotel_checkout dut (
    .clk(clk), .rst_n(rst_n), .book_valid(book_valid), .book_id(book_id),
    .book_room(book_room), .book_ac(book_ac), .book_wifi(book_wifi),
    .book_day(book_day), .co_req(co_req), .co_id(co_id), .co_day(co_day),
    .busy(busy), .co_done(co_done), .co_miss(co_miss), .co_room(co_room),
    .co_bill(co_bill), .occ(occ)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] m_occ_vec();
    logic [6:0] v = '0;
    for (int i = 0; i < 7; i++) v[i] = m_occ[i];
    return v;
  endfunction

  function automatic int nightly(int slot);
    int r = (slot < 2) ? 700 : (slot < 6) ? 400 : 500;
    if (m_ac[slot])   r += 200;
    if (m_wifi[slot]) r += 100;
    return r;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 7; i++) begin
      m_occ[i] = 0; m_id[i] = 0; m_day[i] = 0; m_ac[i] = 0; m_wifi[i] = 0;
    end
  endtask

  task automatic book(input int id, input int room, input bit ac, input bit wifi, input int day);
    @(negedge clk);
    book_valid = 1'b1; book_id = 4'(id); book_room = 3'(room);
    book_ac = ac; book_wifi = wifi; book_day = 5'(day);
    @(posedge clk); #1;
    book_valid = 1'b0;
    if (id != 0 && room < 7) begin
      m_occ[room] = 1; m_id[room] = id; m_ac[room] = ac; m_wifi[room] = wifi; m_day[room] = day;
    end
  endtask

  // Issue a checkout and check result, latency, pulse width and freed slot.
  task automatic checkout(input int id, input int day, input string name);
    int slot = -1, exp_lat, exp_bill = 0, stay, lat = 0;
    bit got = 0;
    if (id != 0)
      for (int i = 6; i >= 0; i--) if (m_occ[i] && m_id[i] == id) slot = i;
    if (id == 0)       exp_lat = 1;
    else if (slot < 0) exp_lat = 7;
    else begin
      exp_lat = slot + 2;
      stay = (day - m_day[slot]) % 32;
      if (stay < 0) stay += 32;
      if (stay == 0) stay = 1;
      exp_bill = nightly(slot) * stay;
    end
    @(negedge clk);
    co_req = 1'b1; co_id = 4'(id); co_day = 5'(day);
    @(posedge clk); #1;
    co_req = 1'b0;
    for (int n = 1; n <= 20 && !got; n++) begin
      @(posedge clk); #1;
      if (co_done) begin got = 1; lat = n; end
    end
    n_tests++;
    if (!got || lat != exp_lat) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d (done=%0b) expected %0d", name, lat, got, exp_lat);
    end
    n_tests++;
    if (co_miss !== (slot < 0) || co_bill !== 16'(exp_bill) ||
        co_room !== ((slot < 0) ? 3'd0 : 3'(slot))) begin
      n_fail++;
      $display("FAIL %s_result: miss=%0b room=%0d bill=%0d expected miss=%0b room=%0d bill=%0d",
               name, co_miss, co_room, co_bill, slot < 0, (slot < 0) ? 0 : slot, exp_bill);
    end
    if (slot >= 0) begin m_occ[slot] = 0; m_id[slot] = 0; end
    @(posedge clk); #1;
    n_tests++;
    if (co_done !== 1'b0 || busy !== 1'b0 || occ !== m_occ_vec()) begin
      n_fail++;
      $display("FAIL %s_after: done=%0b busy=%0b occ=%b expected 0 0 %b",
               name, co_done, busy, occ, m_occ_vec());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; m_clear();
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if ({busy, co_done, co_miss, co_room, co_bill, occ} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%0b done=%0b miss=%0b room=%0d bill=%0d occ=%b expected all 0",
               busy, co_done, co_miss, co_room, co_bill, occ);
    end
  endtask

  task automatic test_basic();
    book(5, 0, 1, 0, 3);
    @(posedge clk); #1;
    n_tests++;
    if (occ !== 7'b0000001) begin
      n_fail++; $display("FAIL basic_occ: got %b expected 0000001", occ);
    end
    checkout(5, 6, "basic");
  endtask

  task automatic test_wrap();
    book(9, 6, 0, 1, 30);
    checkout(9, 2, "wrap");
  endtask

  task automatic test_lowest();
    book(3, 3, 0, 0, 10);
    checkout(3, 10, "sameday");
    book(3, 1, 0, 1, 4);
    book(3, 4, 1, 1, 2);
    checkout(3, 9, "lowest1");
    checkout(3, 9, "lowest2");
  endtask

  task automatic test_miss();
    book(7, 2, 1, 0, 1);
    checkout(12, 5, "miss12");
    checkout(0, 5, "miss0");
    checkout(7, 1, "cleanup");
  endtask

  task automatic test_ignored();
    book(0, 1, 1, 1, 1);
    book(6, 7, 1, 1, 1);
    book(11, 6, 1, 1, 20);
    // During the long scan, a booking and a second request must both be dropped.
    @(negedge clk);
    co_req = 1'b1; co_id = 4'd11; co_day = 5'd25;
    @(posedge clk); #1;
    co_id = 4'd1; co_day = 5'd0;
    book_valid = 1'b1; book_id = 4'd2; book_room = 3'd0; book_day = 5'd0;
    repeat (3) @(posedge clk);
    #1; co_req = 1'b0; book_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    n_tests++;
    if (co_miss !== 1'b0 || co_room !== 3'd6 || co_bill !== 16'd4000) begin
      n_fail++;
      $display("FAIL busy_ignore: miss=%0b room=%0d bill=%0d expected 0 6 4000", co_miss, co_room, co_bill);
    end
    m_occ[6] = 0; m_id[6] = 0;
    n_tests++;
    if (occ !== m_occ_vec()) begin
      n_fail++; $display("FAIL ignored_occ: got %b expected %b", occ, m_occ_vec());
    end
  endtask

  task automatic test_same_edge();
    int lat = 0;
    bit got = 0;
    @(negedge clk);
    book_valid = 1'b1; book_id = 4'd8; book_room = 3'd2; book_ac = 1'b0; book_wifi = 1'b1; book_day = 5'd5;
    co_req = 1'b1; co_id = 4'd8; co_day = 5'd8;
    @(posedge clk); #1;
    book_valid = 1'b0; co_req = 1'b0;
    for (int n = 1; n <= 20 && !got; n++) begin
      @(posedge clk); #1;
      if (co_done) begin got = 1; lat = n; end
    end
    n_tests++;
    if (!got || lat != 4 || co_miss !== 1'b0 || co_room !== 3'd2 || co_bill !== 16'd1500) begin
      n_fail++;
      $display("FAIL same_edge: done=%0b lat=%0d miss=%0b room=%0d bill=%0d expected 1 4 0 2 1500",
               got, lat, co_miss, co_room, co_bill);
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    book(4, 5, 0, 0, 1);
    @(negedge clk);
    co_req = 1'b1; co_id = 4'd12; co_day = 5'd3;
    @(posedge clk); #1; co_req = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b0; m_clear();
    #1;
    n_tests++;
    if (busy !== 1'b0 || occ !== 7'd0 || co_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%0b occ=%b done=%0b expected 0 0 0", busy, occ, co_done);
    end
    for (int n = 0; n < 4; n++) begin @(posedge clk); #1; if (co_done) seen = 1; end
    @(negedge clk); rst_n = 1'b1;
    for (int n = 0; n < 8; n++) begin @(posedge clk); #1; if (co_done) seen = 1; end
    n_tests++;
    if (seen) begin n_fail++; $display("FAIL reset_abort: got co_done=1 expected 0"); end
    book(4, 5, 0, 0, 1);
    checkout(4, 3, "post_reset");
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) != 0)
        book($urandom_range(0, 5), $urandom_range(0, 7), 1'($urandom), 1'($urandom), $urandom_range(0, 31));
      else
        checkout($urandom_range(0, 6), $urandom_range(0, 31), "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_lowest();
    test_miss();
    test_ignored();
    test_same_edge();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
